// File: rtl/syn_pxl_xfr_port_if.sv
// Pixel transfer port bundle: upstream request channel plus the shared pixel bus.
// The slave modport is the port's view; the master modport is the requester/bus-observer view.
interface syn_pxl_xfr_port_if #(
    parameter int PXL_W  = 24,
    parameter int WIDTHX = 10,
    parameter int WIDTHY = 9
);
    logic [PXL_W-1:0]  req_pxl_i;
    logic [WIDTHX-1:0] req_posx_i;
    logic [WIDTHY-1:0] req_posy_i;
    logic              req_wr_i;
    logic              req_rd_i;
    logic              req_rdy_o;
    logic              stall_i;
    logic [PXL_W-1:0]  pxl;
    logic              pxl_wr_valid;
    logic              pxl_rd_valid;
    logic [WIDTHX-1:0] posx;
    logic [WIDTHY-1:0] posy;
    logic              err_o;
    logic [15:0]       oob_cnt_o;

    modport slave (
        input  req_pxl_i, req_posx_i, req_posy_i, req_wr_i, req_rd_i, stall_i,
        output req_rdy_o, pxl, pxl_wr_valid, pxl_rd_valid, posx, posy, err_o, oob_cnt_o
    );

    modport master (
        output req_pxl_i, req_posx_i, req_posy_i, req_wr_i, req_rd_i, stall_i,
        input  req_rdy_o, pxl, pxl_wr_valid, pxl_rd_valid, posx, posy, err_o, oob_cnt_o
    );
endinterface

// File: rtl/syn_pxl_xfr_port.sv
// Pixel transfer port: bounds-checked request FIFO draining onto the pixel bus under stall control.
// Optional out-of-range drop counter enabled by defining SYN_PXL_XFR_OOB_CNT_EN.
module syn_pxl_xfr_port #(
    parameter int PXL_W  = 24,
    parameter int WIDTHX = 10,
    parameter int WIDTHY = 9,
    parameter int MAX_X  = 640,
    parameter int MAX_Y  = 480,
    parameter int DEPTH  = 4
) (
    input logic                clk_ir,
    input logic                rst_il,
    syn_pxl_xfr_port_if.slave  bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int ENT_W = 1 + PXL_W + WIDTHX + WIDTHY;
    localparam logic [WIDTHX:0] MAX_X_V = (WIDTHX+1)'(MAX_X);
    localparam logic [WIDTHY:0] MAX_Y_V = (WIDTHY+1)'(MAX_Y);

    logic [ENT_W-1:0]  mem [DEPTH];
    logic [AW:0]       wr_ptr_reg, rd_ptr_reg;
    logic              full, empty, req_any, in_range, push, pop;
    logic [ENT_W-1:0]  head;
    logic              err_reg;
    logic [PXL_W-1:0]  pxl_reg;
    logic [WIDTHX-1:0] posx_reg;
    logic [WIDTHY-1:0] posy_reg;
    logic              wr_valid_reg, rd_valid_reg;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) && (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    assign req_any  = bus.req_wr_i | bus.req_rd_i;
    assign in_range = ({1'b0, bus.req_posx_i} < MAX_X_V) && ({1'b0, bus.req_posy_i} < MAX_Y_V);
    assign push     = req_any & ~full & in_range;
    assign pop      = ~empty & ~bus.stall_i;
    assign head     = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk_ir) begin
        if (push)
            mem[wr_ptr_reg[AW-1:0]] <= {bus.req_wr_i, bus.req_pxl_i, bus.req_posx_i, bus.req_posy_i};
    end

    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            // A combined write+read keeps the write (is_wr follows req_wr_i) and flags the lost read.
            if (bus.req_wr_i & bus.req_rd_i & ~full) err_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            pxl_reg      <= '0;
            posx_reg     <= '0;
            posy_reg     <= '0;
            wr_valid_reg <= 1'b0;
            rd_valid_reg <= 1'b0;
        end else begin
            wr_valid_reg <= pop & head[ENT_W-1];
            rd_valid_reg <= pop & ~head[ENT_W-1];
            if (pop) begin
                pxl_reg  <= head[ENT_W-2 -: PXL_W];
                posx_reg <= head[WIDTHX+WIDTHY-1 -: WIDTHX];
                posy_reg <= head[WIDTHY-1:0];
            end
        end
    end

`ifdef SYN_PXL_XFR_OOB_CNT_EN
    logic        oob_drop;
    logic [15:0] oob_cnt_reg;

    assign oob_drop = req_any & ~full & ~in_range;

    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il)
            oob_cnt_reg <= '0;
        else if (oob_drop && oob_cnt_reg != 16'hFFFF)
            oob_cnt_reg <= oob_cnt_reg + 16'd1;
    end

    assign bus.oob_cnt_o = oob_cnt_reg;
`else
    assign bus.oob_cnt_o = '0;
`endif

    assign bus.req_rdy_o    = ~full;
    assign bus.err_o        = err_reg;
    assign bus.pxl          = pxl_reg;
    assign bus.posx         = posx_reg;
    assign bus.posy         = posy_reg;
    assign bus.pxl_wr_valid = wr_valid_reg;
    assign bus.pxl_rd_valid = rd_valid_reg;
endmodule

// File: tb/tb_syn_pxl_xfr_port.sv
// Directed bench for syn_pxl_xfr_port: reference occupancy model feeds a scoreboard queue
// that is drained and compared whenever the DUT strobes the pixel bus.
module tb_syn_pxl_xfr_port;
    localparam int PXL_W = 24, WX = 10, WY = 9, MAX_X = 640, MAX_Y = 480, DEPTH = 4;

    typedef struct {
        logic              is_wr;
        logic [PXL_W-1:0]  pxl;
        logic [WX-1:0]     x;
        logic [WY-1:0]     y;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   run = 1'b0;

    ent_t q[$];
    int   m_count;
    logic exp_pop;
    logic m_err;
    logic [15:0] m_oob;

    always #5 clk = ~clk;

    syn_pxl_xfr_port_if #(.PXL_W(PXL_W), .WIDTHX(WX), .WIDTHY(WY)) bif();

    syn_pxl_xfr_port #(
        .PXL_W(PXL_W), .WIDTHX(WX), .WIDTHY(WY),
        .MAX_X(MAX_X), .MAX_Y(MAX_Y), .DEPTH(DEPTH)
    ) dut (
        .clk_ir(clk),
        .rst_il(rst_n),
        .bus(bif.slave)
    );

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: acceptance, occupancy, error and drop counting from driven inputs only.
    always @(posedge clk or negedge rst_n) begin
        bit acc, inr, push, pop;
        if (!rst_n) begin
            m_count <= 0;
            exp_pop <= 1'b0;
            m_err   <= 1'b0;
            m_oob   <= 16'd0;
            q.delete();
        end else begin
            acc  = (bif.req_wr_i || bif.req_rd_i) && (m_count < DEPTH);
            inr  = (int'(bif.req_posx_i) < MAX_X) && (int'(bif.req_posy_i) < MAX_Y);
            push = acc && inr;
            pop  = (m_count > 0) && !bif.stall_i;
            if (push) q.push_back('{bif.req_wr_i, bif.req_pxl_i, bif.req_posx_i, bif.req_posy_i});
            m_count <= m_count + int'(push) - int'(pop);
            exp_pop <= pop;
            if (acc && bif.req_wr_i && bif.req_rd_i) m_err <= 1'b1;
`ifdef SYN_PXL_XFR_OOB_CNT_EN
            if (acc && !inr && m_oob != 16'hFFFF) m_oob <= m_oob + 16'd1;
`endif
        end
    end

    // Monitor: per-cycle status checks; each bus strobe pops and compares one scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && run) begin
            ent_t e;
            chk("strobes_exclusive", 64'(bif.pxl_wr_valid & bif.pxl_rd_valid), 64'd0);
            chk("strobe_expected", 64'(bif.pxl_wr_valid | bif.pxl_rd_valid), 64'(exp_pop));
            chk("req_rdy", 64'(bif.req_rdy_o), 64'(m_count < DEPTH));
            chk("err", 64'(bif.err_o), 64'(m_err));
            chk("oob_cnt", 64'(bif.oob_cnt_o), 64'(m_oob));
            if (bif.pxl_wr_valid || bif.pxl_rd_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("is_wr", 64'(bif.pxl_wr_valid), 64'(e.is_wr));
                    chk("pxl", 64'(bif.pxl), 64'(e.pxl));
                    chk("posx", 64'(bif.posx), 64'(e.x));
                    chk("posy", 64'(bif.posy), 64'(e.y));
                    $display("xfr %s pxl=%06h x=%0d y=%0d", e.is_wr ? "wr" : "rd", bif.pxl, bif.posx, bif.posy);
                end
            end
        end
    end

    task automatic drive(bit w, bit r, logic [PXL_W-1:0] p, int x, int y);
        bif.req_wr_i   = w;
        bif.req_rd_i   = r;
        bif.req_pxl_i  = p;
        bif.req_posx_i = WX'(x);
        bif.req_posy_i = WY'(y);
    endtask

    task automatic send(bit w, bit r, logic [PXL_W-1:0] p, int x, int y);
        @(negedge clk);
        drive(w, r, p, x, y);
        @(posedge clk);
        #1;
        bif.req_wr_i = 1'b0;
        bif.req_rd_i = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_state(string tag);
        chk({tag, "_wr_valid"}, 64'(bif.pxl_wr_valid), 64'd0);
        chk({tag, "_rd_valid"}, 64'(bif.pxl_rd_valid), 64'd0);
        chk({tag, "_pxl"}, 64'(bif.pxl), 64'd0);
        chk({tag, "_posx"}, 64'(bif.posx), 64'd0);
        chk({tag, "_posy"}, 64'(bif.posy), 64'd0);
        chk({tag, "_rdy"}, 64'(bif.req_rdy_o), 64'd1);
        chk({tag, "_err"}, 64'(bif.err_o), 64'd0);
        chk({tag, "_oob"}, 64'(bif.oob_cnt_o), 64'd0);
    endtask

    initial begin
        drive(1'b0, 1'b0, '0, 0, 0);
        bif.stall_i = 1'b0;
        #12;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        run   = 1'b1;

        // Single write, two-edge latency.
        send(1'b1, 1'b0, 24'hAABBCC, 5, 7);
        @(negedge clk);
        chk("lat_not_yet", 64'(bif.pxl_wr_valid), 64'd0);
        @(negedge clk);
        chk("lat_wr_valid", 64'(bif.pxl_wr_valid), 64'd1);
        chk("lat_pxl", 64'(bif.pxl), 64'hAABBCC);
        idle(3);
        chk("hold_pxl_idle", 64'(bif.pxl), 64'hAABBCC);

        // Fill under stall; fifth request ignored.
        @(negedge clk);
        bif.stall_i = 1'b1;
        for (int i = 0; i < 5; i++) send(1'b1, 1'b0, 24'h100000 + 24'(i), 10 + i, 20 + i);
        @(negedge clk);
        chk("full_rdy_low", 64'(bif.req_rdy_o), 64'd0);
        bif.stall_i = 1'b0;
        idle(8);

        // Push at full while a pop happens in the same cycle: refused.
        bif.stall_i = 1'b1;
        for (int i = 0; i < 4; i++) send(1'b0, 1'b1, 24'h200000 + 24'(i), 30 + i, 40 + i);
        @(negedge clk);
        bif.stall_i = 1'b0;
        drive(1'b1, 1'b0, 24'hDEAD00, 99, 99);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, '0, 0, 0);
        idle(8);

        // Out-of-range requests.
        send(1'b1, 1'b0, 24'h123456, 640, 0);
        send(1'b1, 1'b0, 24'h654321, 0, 480);
        send(1'b1, 1'b0, 24'h0F0F0F, 639, 479);
        idle(4);
`ifdef SYN_PXL_XFR_OOB_CNT_EN
        chk("oob_two", 64'(bif.oob_cnt_o), 64'd2);
`else
        chk("oob_two", 64'(bif.oob_cnt_o), 64'd0);
`endif

        // Simultaneous write and read.
        send(1'b1, 1'b1, 24'h111111, 1, 1);
        idle(3);
        chk("err_sticky", 64'(bif.err_o), 64'd1);

        // Interleaved ordering, back to back.
        send(1'b0, 1'b1, 24'h000000, 3, 3);
        send(1'b1, 1'b0, 24'h444444, 4, 4);
        send(1'b0, 1'b1, 24'h000000, 5, 5);
        idle(6);
        chk("err_still_set", 64'(bif.err_o), 64'd1);

        // Reset mid-operation discards queued entries.
        bif.stall_i = 1'b1;
        send(1'b1, 1'b0, 24'hBADBAD, 2, 2);
        send(1'b1, 1'b0, 24'hBADBAD, 3, 3);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check_reset_state("midreset");
        bif.stall_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);
        send(1'b1, 1'b0, 24'hC0FFEE, 8, 9);
        idle(4);

        chk("scoreboard_empty", 64'(q.size()), 64'd0);
        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
